// File: rtl/controlador_alarme_cinto.sv
// Seat-belt warning controller: synchronised and debounced cabin inputs drive
// a grace / blinking-alert / silenced sequence on the dashboard lamp and chime.
module controlador_alarme_cinto #(
    parameter int TICK_DIV = 1000,
    parameter int DEB      = 4,
    parameter int T_GRACE  = 10,
    parameter int T_BLINK  = 2,
    parameter int T_ALARM  = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       motorista,
    input  logic       cinto,
    input  logic       ignicao,
    output logic       luz,
    output logic       sirene,
    output logic [2:0] estado
);

    localparam logic [2:0] DESLIGADO = 3'd0;
    localparam logic [2:0] MONITOR   = 3'd1;
    localparam logic [2:0] CARENCIA  = 3'd2;
    localparam logic [2:0] ALERTA    = 3'd3;
    localparam logic [2:0] SILENCIO  = 3'd4;

    localparam int TMAX = (T_GRACE > T_ALARM) ? T_GRACE : T_ALARM;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int PW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int BW   = $clog2(T_BLINK + 1);
    localparam int DW   = $clog2(DEB + 1);

    logic [1:0]    mot_r, cin_r, ign_r;
    logic          mot_s, cinto_s, ign_s;
    logic          cinto_d;
    logic [DW-1:0] deb_cnt;
    logic [PW-1:0] pre_cnt;
    logic          tick;
    logic          cond;
    logic [TW-1:0] tmr;
    logic [BW-1:0] bcnt, bcnt_nxt;
    logic          phase, phase_nxt;
    logic [2:0]    nxt;

    assign mot_s   = mot_r[1];
    assign cinto_s = cin_r[1];
    assign ign_s   = ign_r[1];
    assign cond    = mot_s & ~cinto_d & ign_s;
    assign tick    = (pre_cnt == PW'(TICK_DIV - 1));

    // Two-flop synchronisers for the asynchronous cabin sensors
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mot_r <= '0;
            cin_r <= '0;
            ign_r <= '0;
        end else begin
            mot_r <= {mot_r[0], motorista};
            cin_r <= {cin_r[0], cinto};
            ign_r <= {ign_r[0], ignicao};
        end
    end

    // Belt debounce: accept a new value after DEB consecutive differing samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cinto_d <= 1'b0;
            deb_cnt <= '0;
        end else if (cinto_s == cinto_d) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DW'(DEB - 1)) begin
            cinto_d <= cinto_s;
            deb_cnt <= '0;
        end else begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end

    // Free-running prescaler producing one tick every TICK_DIV cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    pre_cnt <= '0;
        else if (tick) pre_cnt <= '0;
        else           pre_cnt <= pre_cnt + 1'b1;
    end

    // Next-state logic; ignition loss overrides everything
    always_comb begin
        nxt = estado;
        if (!ign_s) begin
            nxt = DESLIGADO;
        end else begin
            case (estado)
                DESLIGADO: nxt = MONITOR;
                MONITOR:   if (cond) nxt = CARENCIA;
                CARENCIA:
                    if (!cond) nxt = MONITOR;
                    else if (tick && tmr == TW'(T_GRACE - 1)) nxt = ALERTA;
                ALERTA:
                    if (!cond) nxt = MONITOR;
                    else if (tick && tmr == TW'(T_ALARM - 1)) nxt = SILENCIO;
                SILENCIO:  if (!cond) nxt = MONITOR;
                default:   nxt = DESLIGADO;
            endcase
        end
    end

    // Blink phase: starts lit on alert entry, toggles every T_BLINK ticks
    always_comb begin
        phase_nxt = phase;
        bcnt_nxt  = bcnt;
        if (nxt == ALERTA && estado != ALERTA) begin
            phase_nxt = 1'b1;
            bcnt_nxt  = '0;
        end else if (nxt == ALERTA && tick) begin
            if (bcnt == BW'(T_BLINK - 1)) begin
                phase_nxt = ~phase;
                bcnt_nxt  = '0;
            end else begin
                bcnt_nxt = bcnt + 1'b1;
            end
        end
    end

    // State, per-state tick timer, blink registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado <= DESLIGADO;
            tmr    <= '0;
            bcnt   <= '0;
            phase  <= 1'b0;
            luz    <= 1'b0;
            sirene <= 1'b0;
        end else begin
            estado <= nxt;
            // a tick coinciding with the state change is deliberately dropped
            if (nxt != estado) tmr <= '0;
            else if (tick)     tmr <= tmr + 1'b1;
            bcnt  <= bcnt_nxt;
            phase <= phase_nxt;
            case (nxt)
                CARENCIA, SILENCIO: begin luz <= 1'b1;      sirene <= 1'b0;      end
                ALERTA:             begin luz <= phase_nxt; sirene <= phase_nxt; end
                default:            begin luz <= 1'b0;      sirene <= 1'b0;      end
            endcase
        end
    end

endmodule

// File: tb/tb_controlador_alarme_cinto.sv
// Directed bench: a timeline of {inputs, cycles to advance, expected outputs}
// records plus hand-written reset and long-idle sequences.
module tb_controlador_alarme_cinto;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       motorista = 1'b0, cinto = 1'b0, ignicao = 1'b0;
    logic       luz, sirene;
    logic [2:0] estado;

    int total  = 0;
    int passed = 0;

    typedef struct {
        logic       mot, cin, ign;
        int         adv;
        logic [2:0] est;
        logic       luz, sir;
    } vec_t;

    vec_t vecs[$];

    controlador_alarme_cinto #(
        .TICK_DIV(4), .DEB(2), .T_GRACE(3), .T_BLINK(2), .T_ALARM(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .motorista(motorista), .cinto(cinto),
        .ignicao(ignicao), .luz(luz), .sirene(sirene), .estado(estado)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [2:0] e, input logic l, input logic s);
        total++;
        if (estado !== e || luz !== l || sirene !== s)
            $display("FAIL %s: got estado=%0d luz=%b sirene=%b, want estado=%0d luz=%b sirene=%b",
                     nm, estado, luz, sirene, e, l, s);
        else
            passed++;
    endtask

    task automatic add(input logic m, input logic c, input logic g, input int a,
                       input logic [2:0] e, input logic l, input logic s);
        vec_t v;
        v.mot = m; v.cin = c; v.ign = g; v.adv = a; v.est = e; v.luz = l; v.sir = s;
        vecs.push_back(v);
    endtask

    initial begin
        // Timeline; comments give the clk edge count after reset release.
        // Prescaler ticks are consumed on edges 4, 8, 12, ...
        add(1,0,1,  2, 0,0,0); // e2  synchroniser latency
        add(1,0,1,  1, 1,0,0); // e3  MONITOR
        add(1,0,1,  1, 2,1,0); // e4  CARENCIA, entry tick ignored
        add(1,0,1, 11, 2,1,0); // e15
        add(1,0,1,  1, 3,1,1); // e16 ALERTA (ticks 8,12,16)
        add(1,0,1,  7, 3,1,1); // e23
        add(1,0,1,  1, 3,0,0); // e24 first toggle
        add(1,0,1,  8, 3,1,1); // e32
        add(1,0,1,  8, 3,0,0); // e40
        add(1,0,1,  7, 3,0,0); // e47
        add(1,0,1,  1, 4,1,0); // e48 SILENCIO, 32 cycles after ALERTA
        add(1,0,1, 20, 4,1,0); // e68
        add(1,0,0,  2, 4,1,0); // e70 ignition dropped
        add(1,0,0,  1, 0,0,0); // e71 DESLIGADO after 3 cycles
        add(1,0,1,  3, 1,0,0); // e74 MONITOR
        add(1,0,1,  1, 2,1,0); // e75 CARENCIA
        add(1,0,1,  8, 2,1,0); // e83
        add(1,0,1,  1, 3,1,1); // e84 ALERTA (ticks 76,80,84)
        add(1,1,1,  4, 3,1,1); // e88 buckled at e84
        add(1,1,1,  1, 1,0,0); // e89 MONITOR 2+2+1 cycles later
        add(1,0,1,  4, 1,0,0); // e93 unbuckle debounced
        add(1,0,1,  1, 2,1,0); // e94 CARENCIA (off-tick entry)
        add(1,1,1,  1, 2,1,0); // e95 one-cycle glitch
        add(1,0,1,  8, 2,1,0); // e103 timer not restarted
        add(1,0,1,  1, 3,1,1); // e104 ALERTA (ticks 96,100,104)
        add(0,0,1,  2, 3,1,1); // e106 driver leaves
        add(0,0,1,  1, 1,0,0); // e107 MONITOR
        add(1,0,1,  3, 2,1,0); // e110 CARENCIA
        add(1,1,1,  3, 2,1,0); // e113 three-cycle pulse
        add(1,0,1,  1, 2,1,0); // e114
        add(1,0,1,  1, 1,0,0); // e115 MONITOR
        add(1,0,1,  2, 1,0,0); // e117
        add(1,0,1,  1, 2,1,0); // e118 CARENCIA again
        add(1,0,1,  9, 2,1,0); // e127 timer was restarted
        add(1,0,1,  1, 3,1,1); // e128 ALERTA (ticks 120,124,128)
        add(0,0,1,  3, 1,0,0); // e131 MONITOR

        // async reset at start, before any clock edge
        #1 rst_n = 1'b0;
        #1 chk("reset_async", 3'd0, 1'b0, 1'b0);
        step();
        step();
        chk("reset_held", 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            motorista = vecs[i].mot;
            cinto     = vecs[i].cin;
            ignicao   = vecs[i].ign;
            repeat (vecs[i].adv) step();
            chk($sformatf("vec%0d", i), vecs[i].est, vecs[i].luz, vecs[i].sir);
        end

        // no driver for 100 cycles: stays quietly in MONITOR
        for (int i = 0; i < 100; i++) begin
            step();
            chk($sformatf("idle%0d", i), 3'd1, 1'b0, 1'b0);
        end

        // drive back into ALERTA, then reset asynchronously mid-alert
        motorista = 1'b1;
        begin
            int n;
            n = 0;
            while (estado != 3'd3 && n < 40) begin
                step();
                n++;
            end
            total++;
            if (estado != 3'd3)
                $display("FAIL reach_alerta: got estado=%0d after %0d cycles, want estado=3", estado, n);
            else
                passed++;
        end
        #2 rst_n = 1'b0;
        #1 chk("reset_mid_alerta", 3'd0, 1'b0, 1'b0);
        ignicao = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("post_reset%0d", i), 3'd0, 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
